fusion_latency_monitor: RTL
===========================

Name: fusion_latency_monitor

Overview:
Synthesizable, parametrised latency and throughput monitor for the multi-sensor fusion datapath. It replaces the single-counter bench monitor with N_CH independent channels (default: camera, lidar, radar, IMU).
- Each channel timestamps accepted inputs into a per-channel FIFO, so up to DEPTH requests can be in flight at once.
- Each output event is matched in order to the oldest outstanding input.
- Per channel, the block accumulates last, min, max, sum and count, and detects timeouts, overflow and underflow.
- It sits beside MultiSensorFusionTop. Statistics are read through a registered read port.

Parameters:
N_CH, 4, number of monitored channels (1..16)
DEPTH, 4, outstanding-request FIFO depth per channel (power of 2, >=2)
CNT_W, 32, free-running timestamp counter width
SUM_W, 48, latency accumulator width
TIMEOUT_CYC, 1000, cycles after which the oldest outstanding request is declared timed out

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mon_en  in  1  monitor enable; when low, start/stop ignored and timeout checks suspended (timestamp counter keeps running)
clear_stats  in  1  synchronous pulse: zero stats, clear flags, flush FIFOs
ch_start  in  N_CH  per-channel input-accepted strobe
ch_stop  in  N_CH  per-channel output-valid strobe
rd_en  in  1  read request
rd_ch  in  $clog2(N_CH) (min 1)  channel to read
rd_sel  in  3  0 last, 1 min, 2 max, 3 count, 4 sum[31:0], 5 sum[SUM_W-1:32] zero-extended, 6 timeout count, 7 outstanding count
rd_data  out  32  read result (CNT_W fields zero-extended/truncated to 32)
rd_valid  out  1  rd_data valid, one cycle after rd_en
err_flags  out  3*N_CH  sticky per channel {timeout, underflow, overflow} at [3c+2:3c]
any_err  out  1  OR of err_flags

Behaviour:
- Reset (async, rst_n low):
  - Counter, FIFOs, last, max, sum, count, timeout count: all 0.
  - min: all-ones.
  - rd_data=0, rd_valid=0, err_flags=0.
  - Reset mid-measurement discards all in-flight entries; no samples are recorded.
- Timestamp counter:
  - Increments every cycle and wraps modulo 2^CNT_W.
  - latency = (now - head_ts) mod 2^CNT_W, so results are wrap-safe.
- Per channel c, each cycle with mon_en=1, evaluated against the FIFO state at the start of the cycle:
  - Stop with FIFO non-empty: pop head and record sample L.
    - last=L; min=min(min,L); max=max(max,L).
    - sum+=L, saturating at all-ones.
    - count+=1, saturating at 2^32-1.
    - A stop strobe at time T+k for a start at T gives L=k.
  - Stop with FIFO empty: set underflow flag; no sample.
  - Start with FIFO not full: push now.
  - Start with FIFO full and no stop this cycle: set overflow flag; entry dropped.
  - Start and stop in the same cycle with the FIFO full: pop and push both succeed; no overflow.
  - Start and stop in the same cycle with the FIFO empty: underflow is flagged and the start is pushed.
- Timeout:
  - Condition: FIFO non-empty, no stop on c this cycle, and (now - head_ts) >= TIMEOUT_CYC.
  - Action: pop head without a sample, set timeout flag, increment timeout count (saturating).
  - At most one timeout pop per channel per cycle.
- clear_stats:
  - Takes priority over all same-cycle start, stop and timeout events.
  - Stats return to their reset values; flags clear; FIFOs empty; counter unaffected.
- Read port:
  - rd_data and rd_valid are registered; rd_valid is a single-cycle pulse following rd_en.
  - Data reflects stats as of the end of the rd_en cycle, i.e. it includes updates made in that same cycle.
  - rd_ch >= N_CH returns 0 with rd_valid=1.
  - min reads all-ones (truncated to 32 bits) when count=0.
- Channels are fully independent; simultaneous events on different channels are all processed.
- Implementation: registered stats, FIFO as RAM array with wrap pointers plus an occupancy counter of $clog2(DEPTH)+1 bits.

Test Plan:
1. Reset, mon_en=1; ch_start[0] at cycle 10, ch_stop[0] at cycle 17; read sel 0,1,2,3 -> 7, 7, 7, 1; rd_valid exactly one cycle after each rd_en.
2. Pipelined ch 2: starts at cycles 0,1,2, stops at 5,9,10 -> samples 5,8,8; min=5, max=8, sum=21, count=3, outstanding=0.
3. Overflow/underflow ch 1, DEPTH=4: 5 starts with no stop -> overflow flag (err_flags[3]=1), outstanding=4; then 5 stops -> 4 samples, underflow flag (err_flags[4]=1), any_err=1; start+stop same cycle while full -> no new overflow.
4. Timeout, TIMEOUT_CYC=1000: ch_start[3], no stop -> 1000 cycles later the timeout flag (err_flags[11]) is set, timeout count=1, outstanding=0, count=0; a later stop -> underflow.
5. Wrap, CNT_W=8: start at counter 250, stop 10 cycles later (counter 4) -> latency 10; clear_stats in the same cycle as a stop -> count=0, min=0xFF, flags 0.
6. Reset mid-operation: 2 outstanding on ch 0, assert rst_n=0 asynchronously between edges -> all outputs 0 immediately; after release, stop -> underflow only.

Source files
------------

// File: rtl/fusion_latency_monitor_if.sv
// Control strobes and statistics read port of the fusion latency monitor.
// The master side drives the strobes and read requests; the monitor is the slave.
interface fusion_latency_monitor_if #(
    parameter int unsigned N_CH = 4
);
    localparam int unsigned RD_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                mon_en;
    logic                clear_stats;
    logic [N_CH-1:0]     ch_start;
    logic [N_CH-1:0]     ch_stop;
    logic                rd_en;
    logic [RD_W-1:0]     rd_ch;
    logic [2:0]          rd_sel;
    logic [31:0]         rd_data;
    logic                rd_valid;
    logic [3*N_CH-1:0]   err_flags;
    logic                any_err;

    modport master (
        output mon_en, clear_stats, ch_start, ch_stop, rd_en, rd_ch, rd_sel,
        input  rd_data, rd_valid, err_flags, any_err
    );

    modport slave (
        input  mon_en, clear_stats, ch_start, ch_stop, rd_en, rd_ch, rd_sel,
        output rd_data, rd_valid, err_flags, any_err
    );
endinterface

// File: rtl/fusion_latency_monitor.sv
// Per-channel latency monitor: timestamps starts into a FIFO, matches stops in order,
// and keeps last/min/max/sum/count, timeout count and sticky error flags per channel.
module fusion_latency_monitor #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SUM_W       = 48,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fusion_latency_monitor_if.slave bus
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned OCC_W  = AW + 1;
    localparam int unsigned RD_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CMP_W  = (CNT_W > 32) ? CNT_W : 32;
    localparam int unsigned SUMX_W = (SUM_W > 64) ? SUM_W : 64;
    localparam int unsigned SUM1_W = SUM_W + 1;

    // Registered state
    logic [CNT_W-1:0]  ts_q;
    logic [CNT_W-1:0]  mem_q  [N_CH][DEPTH];
    logic [AW-1:0]     rptr_q [N_CH];
    logic [AW-1:0]     wptr_q [N_CH];
    logic [OCC_W-1:0]  occ_q  [N_CH];
    logic [CNT_W-1:0]  last_q [N_CH];
    logic [CNT_W-1:0]  min_q  [N_CH];
    logic [CNT_W-1:0]  max_q  [N_CH];
    logic [SUM_W-1:0]  sum_q  [N_CH];
    logic [31:0]       cnt_q  [N_CH];
    logic [31:0]       tmo_q  [N_CH];
    logic [3*N_CH-1:0] err_q;
    logic              any_err_q;
    logic [31:0]       rd_data_q;
    logic              rd_valid_q;

    // Next-state values
    logic [AW-1:0]     rptr_n [N_CH];
    logic [AW-1:0]     wptr_n [N_CH];
    logic [OCC_W-1:0]  occ_n  [N_CH];
    logic [CNT_W-1:0]  last_n [N_CH];
    logic [CNT_W-1:0]  min_n  [N_CH];
    logic [CNT_W-1:0]  max_n  [N_CH];
    logic [SUM_W-1:0]  sum_n  [N_CH];
    logic [31:0]       cnt_n  [N_CH];
    logic [31:0]       tmo_n  [N_CH];
    logic [3*N_CH-1:0] err_n;

    // Per-channel event decode
    logic [CNT_W-1:0]  lat    [N_CH];
    logic [SUM1_W-1:0] sumx   [N_CH];
    logic [N_CH-1:0]   empty, full, stop_v, start_v;
    logic [N_CH-1:0]   smp, udf, ovf, tmo, push, pop;
    logic [31:0]       rd_word;

    // Events are decoded against the FIFO state at the start of the cycle.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            lat[c]     = ts_q - mem_q[c][rptr_q[c]];
            empty[c]   = (occ_q[c] == '0);
            full[c]    = (occ_q[c] == OCC_W'(DEPTH));
            stop_v[c]  = bus.mon_en & bus.ch_stop[c];
            start_v[c] = bus.mon_en & bus.ch_start[c];
            smp[c]     = stop_v[c] & ~empty[c];
            udf[c]     = stop_v[c] & empty[c];
            tmo[c]     = bus.mon_en & ~empty[c] & ~bus.ch_stop[c]
                         & (CMP_W'(lat[c]) >= CMP_W'(TIMEOUT_CYC));
            // A same-cycle stop frees the head slot, so a full FIFO still accepts the start.
            ovf[c]     = start_v[c] & full[c] & ~stop_v[c];
            push[c]    = start_v[c] & ~ovf[c] & ~bus.clear_stats;
            pop[c]     = smp[c] | tmo[c];
            sumx[c]    = {1'b0, sum_q[c]} + SUM1_W'(lat[c]);
        end
    end

    // Statistics and FIFO pointer next state; clear_stats overrides every event.
    always_comb begin
        err_n = err_q;
        for (int c = 0; c < N_CH; c++) begin
            rptr_n[c] = rptr_q[c];
            wptr_n[c] = wptr_q[c];
            occ_n[c]  = occ_q[c];
            last_n[c] = last_q[c];
            min_n[c]  = min_q[c];
            max_n[c]  = max_q[c];
            sum_n[c]  = sum_q[c];
            cnt_n[c]  = cnt_q[c];
            tmo_n[c]  = tmo_q[c];
            if (bus.clear_stats) begin
                rptr_n[c]          = '0;
                wptr_n[c]          = '0;
                occ_n[c]           = '0;
                last_n[c]          = '0;
                min_n[c]           = '1;
                max_n[c]           = '0;
                sum_n[c]           = '0;
                cnt_n[c]           = '0;
                tmo_n[c]           = '0;
                err_n[3*c +: 3]    = 3'b000;
            end else begin
                if (pop[c])  rptr_n[c] = rptr_q[c] + AW'(1);
                if (push[c]) wptr_n[c] = wptr_q[c] + AW'(1);
                occ_n[c] = occ_q[c] + OCC_W'(push[c]) - OCC_W'(pop[c]);
                if (smp[c]) begin
                    last_n[c] = lat[c];
                    if (lat[c] < min_q[c]) min_n[c] = lat[c];
                    if (lat[c] > max_q[c]) max_n[c] = lat[c];
                    sum_n[c] = sumx[c][SUM_W] ? '1 : sumx[c][SUM_W-1:0];
                    if (cnt_q[c] != 32'hFFFF_FFFF) cnt_n[c] = cnt_q[c] + 32'd1;
                end
                if (tmo[c] && (tmo_q[c] != 32'hFFFF_FFFF)) tmo_n[c] = tmo_q[c] + 32'd1;
                err_n[3*c +: 3] = err_q[3*c +: 3] | {tmo[c], udf[c], ovf[c]};
            end
        end
    end

    // Read mux sees next-state stats so a read includes same-cycle updates.
    always_comb begin
        rd_word = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (RD_W'(c) == bus.rd_ch) begin
                case (bus.rd_sel)
                    3'd0:    rd_word = 32'(last_n[c]);
                    3'd1:    rd_word = 32'(min_n[c]);
                    3'd2:    rd_word = 32'(max_n[c]);
                    3'd3:    rd_word = cnt_n[c];
                    3'd4:    rd_word = 32'(sum_n[c]);
                    3'd5:    rd_word = 32'(SUMX_W'(sum_n[c]) >> 32);
                    3'd6:    rd_word = tmo_n[c];
                    default: rd_word = 32'(occ_n[c]);
                endcase
            end
        end
    end

    // Timestamp storage carries no reset; occupancy defines which entries are live.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (push[c]) mem_q[c][wptr_q[c]] <= ts_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            err_q      <= '0;
            any_err_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                rptr_q[c] <= '0;
                wptr_q[c] <= '0;
                occ_q[c]  <= '0;
                last_q[c] <= '0;
                min_q[c]  <= '1;
                max_q[c]  <= '0;
                sum_q[c]  <= '0;
                cnt_q[c]  <= '0;
                tmo_q[c]  <= '0;
            end
        end else begin
            ts_q       <= ts_q + CNT_W'(1);
            err_q      <= err_n;
            any_err_q  <= |err_n;
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= rd_word;
            for (int c = 0; c < N_CH; c++) begin
                rptr_q[c] <= rptr_n[c];
                wptr_q[c] <= wptr_n[c];
                occ_q[c]  <= occ_n[c];
                last_q[c] <= last_n[c];
                min_q[c]  <= min_n[c];
                max_q[c]  <= max_n[c];
                sum_q[c]  <= sum_n[c];
                cnt_q[c]  <= cnt_n[c];
                tmo_q[c]  <= tmo_n[c];
            end
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.err_flags = err_q;
    assign bus.any_err   = any_err_q;
endmodule
